alu_exec: RTL and testbench
===========================

# alu_exec

Multi-cycle execute stage that consumes the 4-bit ALU control code and two 32-bit operands, computes the result, and returns it under a valid/ready handshake. It sits directly downstream of the ALU control decoder and upstream of writeback and branch resolution. Logic/arithmetic ops complete in one cycle. Arithmetic right shifts (SRA/SRAV) iterate one bit per cycle to keep the datapath small.

## Interface
- Parameters:
- `WIDTH`, 32: operand and result width; shift amount is fixed at 5 bits.
- Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  operation offered.
- `in_ready_o`  out  1  stage can accept; high only in IDLE.
- `alu_ctrl_i`  in  4  operation code: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SRA=8, SRAV=9, LUI=10.
- `src1_i`  in  WIDTH  operand A (rs).
- `src2_i`  in  WIDTH  operand B (rt or extended immediate).
- `shamt_i`  in  5  constant shift amount for SRA.
- `out_valid_o`  out  1  result available.
- `out_ready_i`  in  1  consumer takes result.
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  registered, 1 when `result_o` is 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready_o`=1. On `in_valid_i`, accept and latch the operands and code.
  - Non-shift code: compute the result combinationally, register it, and go to DONE.
  - SRA: load `src2_i` and count=`shamt_i`.
  - SRAV: load `src2_i` and count=`src1_i[4:0]`.
  - For either shift, go to SHIFT if count≠0, otherwise go to DONE with result=`src2_i`.
- SHIFT: each cycle, result = {result[MSB], result[MSB:1]} and count decrements. After the shift that takes count from 1 to 0, go to DONE.
- DONE: `out_valid_o`=1. `result_o` and `zero_o` stay stable until `out_ready_i`. On `out_ready_i`, go to IDLE.
- Arithmetic rules:
  - ADDU/SUBU wrap modulo 2^WIDTH with no overflow flag.
  - SLT is a signed compare returning 1 or 0, zero-extended.
  - EQUAL returns 1 if `src1_i`==`src2_i`, else 0.
  - NAND is ~(A&B). NOR is ~(A|B).
  - LUI returns `src2_i`<<16.
- Codes 11–15 are accepted and return 0, with `zero_o`=1 and 1-cycle latency.
- `zero_o` is computed from the final result, never from intermediate shift values.
- Reset in any state: state=IDLE, `result_o`=0, `zero_o`=1, count=0, `out_valid_o`=0, `in_ready_o`=1 from the first cycle after reset. An in-flight operation is discarded.
- Inputs are ignored outside IDLE. `in_valid_i` in SHIFT or DONE has no effect.

## Timing
- Accept on edge t.
- Non-shift, or shift by 0: `out_valid_o` high after edge t+1.
- Shift by N (1–31): `out_valid_o` high after edge t+1+N.
- Return to IDLE on the edge where `out_valid_o` and `out_ready_i` are both high. `in_ready_o` rises after that edge; there is no same-cycle re-accept.
- Peak throughput: one op per 2 cycles (non-shift), one op per N+2 cycles (shift).
- `out_ready_i` low holds DONE indefinitely with outputs unchanged.

## Structure
- Shared package `alu_pkg`: 4-bit ALU op localparams (values above), state enum, `SHAMT_W`=5.
- Sub-module `alu_core`: purely combinational single-cycle ops (codes 0–7, 10, default). `alu_exec` holds the FSM, shift register, counter and handshake.

## Test plan
- **Reset:** assert `rst_i` mid-SHIFT (SRA by 20, cycle 5) → next cycle `in_ready_o`=1, `out_valid_o`=0, `result_o`=0, `zero_o`=1.
- **Single-cycle ops:**
  - ADDU 0xFFFFFFFF+1 → `result_o`=0 and `zero_o`=1, one cycle after accept.
  - SUBU 5−7 → 0xFFFFFFFE.
  - SLT −1 vs 1 → 1.
  - NOR 0 vs 0 → 0xFFFFFFFF.
  - LUI `src2_i`=0x1234 → 0x12340000.
- **SRA constant:** `src2_i`=0x80000000, `shamt_i`=4 → `out_valid_o` exactly 5 cycles after accept, `result_o`=0xF8000000.
- **SRAV and zero shift:**
  - `src1_i`=0x23 (amount 3), `src2_i`=0x40 → 0x8 after 4 cycles.
  - `src1_i`=0x20 (amount 0) → `src2_i` unchanged, 1 cycle.
- **Backpressure:** hold `out_ready_i`=0 for 10 cycles in DONE while toggling `in_valid_i` and operands → `result_o` stable, no accept. Release → IDLE next cycle.
- **Illegal code:** `alu_ctrl_i`=13 → `result_o`=0, `zero_o`=1, 1-cycle latency. Back-to-back EQUAL 7==7 → 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM states, shift width.
package alu_pkg;

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 4;

  localparam logic [OP_W-1:0] ALU_AND   = 4'd0;
  localparam logic [OP_W-1:0] ALU_OR    = 4'd1;
  localparam logic [OP_W-1:0] ALU_NAND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_NOR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_ADDU  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SUBU  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLT   = 4'd6;
  localparam logic [OP_W-1:0] ALU_EQUAL = 4'd7;
  localparam logic [OP_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRAV  = 4'd9;
  localparam logic [OP_W-1:0] ALU_LUI   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Ops that go through the iterative shifter instead of the single-cycle core.
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == ALU_SRA) || (op == ALU_SRAV);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU ops; shift and unused codes produce zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_NAND:  y = ~(a & b);
      ALU_NOR:   y = ~(a | b);
      ALU_ADDU:  y = a + b;
      ALU_SUBU:  y = a - b;
      ALU_SLT:   y = WIDTH'($signed(a) < $signed(b));
      ALU_EQUAL: y = WIDTH'(a == b);
      ALU_LUI:   y = WIDTH'(b << 16);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage: single-cycle ALU ops plus bit-serial arithmetic
// right shifts, with a valid/ready handshake on both sides.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [OP_W-1:0]    alu_ctrl_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;
  logic [SHAMT_W-1:0]   count_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [WIDTH-1:0]     core_y;
  logic [WIDTH-1:0]     shift_next_c;
  logic [SHAMT_W-1:0]   load_cnt_c;
  logic                 accept_c;
  logic                 is_shift_c;
  logic                 shift_step_c;
  logic                 last_step_c;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op (alu_ctrl_i),
    .a  (src1_i),
    .b  (src2_i),
    .y  (core_y)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (is_shift_c && (load_cnt_c != '0)) state_d = S_SHIFT;
          else                                  state_d = S_DONE;
        end
      end
      S_SHIFT: begin
        if (last_step_c) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath control decoded from the current state and inputs
  always_comb begin
    accept_c     = 1'b0;
    is_shift_c   = is_shift_op(alu_ctrl_i);
    load_cnt_c   = (alu_ctrl_i == ALU_SRA) ? shamt_i : src1_i[SHAMT_W-1:0];
    shift_step_c = 1'b0;
    last_step_c  = 1'b0;
    shift_next_c = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
    unique case (state_q)
      S_IDLE:  accept_c = in_valid_i;
      S_SHIFT: begin
        shift_step_c = 1'b1;
        // A zero count here is unreachable; treat it as finished rather than wrap.
        last_step_c  = (count_q <= SHAMT_W'(1));
      end
      default: ;
    endcase
  end

  // Result, count and handshake registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      if (accept_c) begin
        if (is_shift_c) begin
          result_q <= src2_i;
          count_q  <= load_cnt_c;
          if (load_cnt_c == '0) zero_q <= ~|src2_i;
        end else begin
          result_q <= core_y;
          count_q  <= '0;
          zero_q   <= ~|core_y;
        end
      end else if (shift_step_c) begin
        result_q <= shift_next_c;
        count_q  <= last_step_c ? '0 : count_q - SHAMT_W'(1);
        // Flag only the final value; intermediate shifts leave zero_q alone.
        if (last_step_c) zero_q <= ~|shift_next_c;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes expected results, monitor pops
// and checks value, zero flag and latency whenever the stage presents a result.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    alu_ctrl;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .alu_ctrl_i  (alu_ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .shamt_i     (shamt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .zero_o      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one op as soon as the stage is ready; optionally record its expectation.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input bit track,
                       input logic [31:0] exp_res, input logic exp_zero, input int exp_lat);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready timeout got 0 expected 1", name);
      return;
    end
    in_valid = 1'b1;
    alu_ctrl = op;
    src1     = a;
    src2     = b;
    shamt    = sh;
    @(posedge clk); #1;
    if (track) sb.push_back('{name, exp_res, exp_zero, exp_lat, cyc});
    in_valid = 1'b0;
  endtask

  // Monitor: first cycle of a result checks it, later held cycles check stability.
  exp_t cur;
  bit   holding = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else if (out_valid) begin
      if (!holding) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got result 0x%08h expected no output", result);
        end else begin
          cur = sb.pop_front();
          chk({cur.name, "_result"}, result, cur.res);
          chk({cur.name, "_zero"}, 32'(zero), 32'(cur.zero));
          chk({cur.name, "_latency"}, 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
          holding = 1'b1;
        end
      end else begin
        chk({cur.name, "_hold_result"}, result, cur.res);
        chk({cur.name, "_hold_zero"}, 32'(zero), 32'(cur.zero));
      end
      if (out_ready) holding = 1'b0;
    end
  end

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_result"}, result, 32'h0);
    chk({name, "_zero"}, 32'(zero), 32'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; src1 = '0; src2 = '0; shamt = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");

    // Single-cycle ops
    issue("addu_wrap", ALU_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 32'h0, 1'b1, 1);
    issue("subu",      ALU_SUBU, 32'd5, 32'd7, 5'd0, 1, 32'hFFFF_FFFE, 1'b0, 1);
    issue("slt_neg",   ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'h1, 1'b0, 1);
    issue("slt_pos",   ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 1'b1, 1);
    issue("nor",       ALU_NOR, 32'h0, 32'h0, 5'd0, 1, 32'hFFFF_FFFF, 1'b0, 1);
    issue("lui",       ALU_LUI, 32'hDEAD_0000, 32'h1234, 5'd0, 1, 32'h1234_0000, 1'b0, 1);
    issue("and",       ALU_AND, 32'hF0F0_00FF, 32'h0FF0_F0F0, 5'd0, 1, 32'h00F0_00F0, 1'b0, 1);
    issue("or",        ALU_OR,  32'hF0F0_00FF, 32'h0FF0_F0F0, 5'd0, 1, 32'hFFF0_F0FF, 1'b0, 1);
    issue("nand",      ALU_NAND, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 1, 32'hF0F0_FFFF, 1'b0, 1);
    issue("equal_ne",  ALU_EQUAL, 32'd7, 32'd8, 5'd0, 1, 32'h0, 1'b1, 1);

    // Shifts: SRA uses shamt, SRAV uses src1[4:0]
    issue("sra4",      ALU_SRA, 32'h0, 32'h8000_0000, 5'd4, 1, 32'hF800_0000, 1'b0, 5);
    issue("srav3",     ALU_SRAV, 32'h23, 32'h40, 5'd17, 1, 32'h8, 1'b0, 4);
    issue("srav0",     ALU_SRAV, 32'h20, 32'hDEAD_BEEF, 5'd9, 1, 32'hDEAD_BEEF, 1'b0, 1);
    issue("sra0_zero", ALU_SRA, 32'h5, 32'h0, 5'd0, 1, 32'h0, 1'b1, 1);
    issue("sra31_pos", ALU_SRA, 32'h0, 32'h7FFF_FFFF, 5'd31, 1, 32'h0, 1'b1, 32);
    issue("sra31_neg", ALU_SRA, 32'h0, 32'h8000_0001, 5'd31, 1, 32'hFFFF_FFFF, 1'b0, 32);

    // Illegal code then back-to-back EQUAL
    issue("illegal13", 4'd13, 32'd5, 32'd6, 5'd3, 1, 32'h0, 1'b1, 1);
    issue("equal_eq",  ALU_EQUAL, 32'd7, 32'd7, 5'd0, 1, 32'h1, 1'b0, 1);
    issue("illegal15", 4'd15, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, 32'h0, 1'b1, 1);

    // Backpressure: result must hold and no new op may be taken
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    out_ready = 1'b0;
    issue("bp_addu", ALU_ADDU, 32'd3, 32'd4, 5'd0, 1, 32'h7, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      alu_ctrl = ALU_OR;
      src1     = 32'hA5A5_0000 + 32'(i);
      src2     = 32'h0000_5A5A;
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of an SRA by 20
    issue("rst_sra20", ALU_SRA, 32'h0, 32'h8000_0000, 5'd20, 0, 32'h0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("mid_shift_reset");
    issue("post_reset", ALU_ADDU, 32'd10, 32'd20, 5'd0, 1, 32'd30, 1'b0, 1);

    w = 0;
    while ((sb.size() != 0 || !in_ready) && w < 200) begin @(posedge clk); #1; w++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
